// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: bus widths, register count and strobe levels.
package regfile_pkg;

   localparam int REGS_ADDR_BUS = 5;
   localparam int REGS_DATA_BUS = 32;
   localparam int REG_NUM       = 32;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [REGS_ADDR_BUS-1:0] ZERO_ADDR = '0;

   typedef logic [REGS_DATA_BUS-1:0] reg_data_t;
   typedef logic [REGS_ADDR_BUS-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     issue_enable,
   input  logic [REGS_ADDR_BUS-1:0] issue_addr,
   input  logic                     write_enable,
   input  logic [REGS_ADDR_BUS-1:0] write_addr,
   output logic [REG_NUM-1:0]       pending
);

   logic [REG_NUM-1:0] pending_q;
   logic [REG_NUM-1:0] pending_d;

   always_comb begin
      pending_d = pending_q;
      if (write_enable == ENABLE && write_addr != ZERO_ADDR) begin
         pending_d[write_addr] = 1'b0;
      end
      // Set is applied after clear: a newer in-flight writer outranks the retiring one.
      if (issue_enable == ENABLE && issue_addr != ZERO_ADDR) begin
         pending_d[issue_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
      if (reset) begin
         pending_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      pending_q <= pending_d;
   end

   assign pending = pending_q;

endmodule

// File: rtl/regfile.sv
// 32x32 register file with combinational, write-bypassed read ports and a hazard scoreboard.
module regfile
   import regfile_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_enable,
   input  logic [REGS_ADDR_BUS-1:0] write_addr,
   input  logic [REGS_DATA_BUS-1:0] write_data,
   input  logic                     read_enable1,
   input  logic [REGS_ADDR_BUS-1:0] read_addr1,
   input  logic                     read_enable2,
   input  logic [REGS_ADDR_BUS-1:0] read_addr2,
   output logic [REGS_DATA_BUS-1:0] read_result1,
   output logic [REGS_DATA_BUS-1:0] read_result2,
   input  logic                     issue_enable,
   input  logic [REGS_ADDR_BUS-1:0] issue_addr,
   output logic                     stall_request
);

   reg_data_t          regs_q [REG_NUM];
   reg_data_t          regs_d [REG_NUM];
   logic [REG_NUM-1:0] pending;
   logic               write_valid;

   logic [1:0]         rd_en;
   reg_addr_t          rd_addr [2];
   reg_data_t          rd_data [2];
   logic [1:0]         rd_stall;

   assign write_valid = (write_enable == ENABLE) && (write_addr != ZERO_ADDR);

   regfile_scoreboard u_scoreboard (
      .clock        (clock),
      .reset        (reset),
      .issue_enable (issue_enable),
      .issue_addr   (issue_addr),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .pending      (pending)
   );

   // Register 0 is held at zero; every other register loads only on a matching writeback.
   assign regs_d[0] = '0;
   for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_reg
      assign regs_d[gi] = reset ? '0 :
                          (write_valid && write_addr == REGS_ADDR_BUS'(gi)) ? write_data :
                          regs_q[gi];
   end

   always_ff @(posedge clock) begin
      regs_q <= regs_d;
   end

   assign rd_en      = {read_enable2, read_enable1};
   assign rd_addr[0] = read_addr1;
   assign rd_addr[1] = read_addr2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic active;
      logic bypass;
      assign active = !reset && rd_en[gi] == ENABLE && rd_addr[gi] != ZERO_ADDR;
      assign bypass = write_valid && write_addr == rd_addr[gi];
      assign rd_data[gi]  = !active ? '0 : (bypass ? write_data : regs_q[rd_addr[gi]]);
      // The writeback landing this cycle satisfies the hazard, so it never stalls.
      assign rd_stall[gi] = active && pending[rd_addr[gi]] && !bypass;
   end

   assign read_result1  = rd_data[0];
   assign read_result2  = rd_data[1];
   assign stall_request = |rd_stall;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic against an array model.
module tb_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        read_enable1, read_enable2;
   logic [4:0]  read_addr1, read_addr2;
   logic [31:0] read_result1, read_result2;
   logic        issue_enable;
   logic [4:0]  issue_addr;
   logic        stall_request;

   int tests  = 0;
   int failed = 0;

   logic [31:0] model_regs [32];
   bit          model_pend [32];

   always #5 clock = ~clock;

   regfile dut (
      .clock         (clock),
      .reset         (reset),
      .write_enable  (write_enable),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .read_enable1  (read_enable1),
      .read_addr1    (read_addr1),
      .read_enable2  (read_enable2),
      .read_addr2    (read_addr2),
      .read_result1  (read_result1),
      .read_result2  (read_result2),
      .issue_enable  (issue_enable),
      .issue_addr    (issue_addr),
      .stall_request (stall_request)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // What a reader should see: zero when idle/reset/r0, the in-flight write if it
   // targets this register, else the stored value.
   function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
      if (reset || !en || a == 0) return 32'h0;
      if (write_enable && write_addr == a) return write_data;
      return model_regs[a];
   endfunction

   function automatic logic exp_stall_port(input logic en, input logic [4:0] a);
      if (reset || !en || a == 0) return 1'b0;
      return model_pend[a] && !(write_enable && write_addr == a);
   endfunction

   // Drive one cycle's inputs mid-cycle and check the combinational outputs against the model.
   task automatic apply(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2,
                        input logic ie, input logic [4:0] ia, input string tag);
      @(negedge clock);
      reset = rst; write_enable = we; write_addr = wa; write_data = wd;
      read_enable1 = re1; read_addr1 = ra1; read_enable2 = re2; read_addr2 = ra2;
      issue_enable = ie; issue_addr = ia;
      #1;
      chk({tag, ".r1"}, read_result1, exp_read(re1, ra1));
      chk({tag, ".r2"}, read_result2, exp_read(re2, ra2));
      chk({tag, ".stall"}, {31'b0, stall_request},
          {31'b0, exp_stall_port(re1, ra1) | exp_stall_port(re2, ra2)});
   endtask

   // Advance through the clock edge and apply the same edge to the model.
   task automatic commit();
      @(posedge clock);
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            model_regs[i] = 32'h0;
            model_pend[i] = 1'b0;
         end
      end else begin
         if (write_enable && write_addr != 0) begin
            model_regs[write_addr] = write_data;
            model_pend[write_addr] = 1'b0;
         end
         if (issue_enable && issue_addr != 0) model_pend[issue_addr] = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1; write_enable = 0; write_addr = 0; write_data = 0;
      read_enable1 = 0; read_addr1 = 0; read_enable2 = 0; read_addr2 = 0;
      issue_enable = 0; issue_addr = 0;
      for (int i = 0; i < 32; i++) begin
         model_regs[i] = 32'h0;
         model_pend[i] = 1'b0;
      end

      // Reset state: outputs held low even with reads enabled.
      apply(1, 0, 0, 0, 1, 5, 1, 9, 0, 0, "reset");
      chk("reset.r1_const", read_result1, 32'h0);
      commit();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset2"); commit();

      // Basic write then read.
      apply(0, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, "wr5"); commit();
      apply(0, 0, 0, 0, 1, 5, 0, 5, 0, 0, "rd5");
      chk("rd5.const", read_result1, 32'h0000_1234);
      chk("rd5.dis_const", read_result2, 32'h0);
      commit();

      // Register zero: write discarded, no stall on issue to 0.
      apply(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, "wr0"); commit();
      apply(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "rd0");
      chk("rd0.const", read_result1 | read_result2 | {31'b0, stall_request}, 32'h0);
      commit();

      // Same-cycle bypass on port 2; both ports on one register.
      apply(0, 1, 7, 32'hDEAD_BEEF, 1, 7, 1, 7, 0, 0, "byp7");
      chk("byp7.const", read_result2, 32'hDEAD_BEEF);
      commit();

      // Scoreboard: issue 9, stall, writeback clears stall in its own cycle.
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, "iss9"); commit();
      apply(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, "stall9");
      chk("stall9.const", {31'b0, stall_request}, 32'h1);
      commit();
      apply(0, 1, 9, 32'h42, 1, 9, 0, 0, 0, 0, "wb9");
      chk("wb9.const", {read_result1[30:0], stall_request}, {31'h42, 1'b0});
      commit();
      apply(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, "after9");
      chk("after9.const", {31'b0, stall_request}, 32'h0);
      commit();

      // Simultaneous set and clear on reg3: set wins.
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, "iss3"); commit();
      apply(0, 1, 3, 32'h0000_0333, 0, 0, 0, 0, 1, 3, "setclr3"); commit();
      apply(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, "rd3");
      chk("rd3.stall_const", {31'b0, stall_request}, 32'h1);
      chk("rd3.data_const", read_result1, 32'h0000_0333);
      commit();

      // Reset mid-operation discards data and pending bits.
      apply(0, 1, 4, 32'h99, 0, 0, 0, 0, 1, 4, "wr4"); commit();
      apply(1, 1, 4, 32'h77, 1, 4, 1, 4, 1, 4, "rst4"); commit();
      apply(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, "post4");
      chk("post4.const", read_result1 | {31'b0, stall_request}, 32'h0);
      commit();

      // Random traffic over a narrow address range to provoke hazards and bypasses.
      for (int n = 0; n < 1500; n++) begin
         apply(($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
               1'($urandom), 5'($urandom_range(0, 7)), "rand");
         commit();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
